// File: rtl/player_motion_ctrl.sv
// Player motion controller: holds the committed heading, steps the grid position once per tick,
// and detects wall/trail crashes. Define PLAYER_WRAP_EN to wrap at grid edges instead of crashing.
module player_motion_ctrl #(
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned GRID_W    = 160,
  parameter int unsigned GRID_H    = 120,
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned START_X   = 20,
  parameter int unsigned START_Y   = 60,
  parameter logic [1:0]  START_DIR = 2'b01
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [1:0]     dir_filtered_i,
  input  logic           collision_i,
  output logic [1:0]     direction_current_o,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o,
  output logic           step_valid_o,
  output logic           alive_o,
  output logic           crashed_o
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

`ifdef PLAYER_WRAP_EN
  localparam bit EdgeCrash = 1'b0;
`else
  localparam bit EdgeCrash = 1'b1;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [X_W-1:0]  pos_x_q, pos_x_d;
  logic [Y_W-1:0]  pos_y_q, pos_y_d;
  logic [1:0]      dir_q;
  logic            step_q, alive_q, crashed_q;
  logic            tick, off_grid;

  assign tick = (state_q == StRun) && (cnt_q == CntW'(TICK_DIV - 1));

  // Edge tests come before the +/-1 so the coordinates never leave their legal range; the
  // wrapped value is only committed when wrapping is enabled.
  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    off_grid = 1'b0;
    unique case (dir_filtered_i)
      2'b00: begin
        if (pos_y_q == '0) begin
          off_grid = 1'b1;
          pos_y_d  = Y_W'(GRID_H - 1);
        end else begin
          pos_y_d = pos_y_q - 1'b1;
        end
      end
      2'b01: begin
        if (pos_x_q == X_W'(GRID_W - 1)) begin
          off_grid = 1'b1;
          pos_x_d  = '0;
        end else begin
          pos_x_d = pos_x_q + 1'b1;
        end
      end
      2'b11: begin
        if (pos_y_q == Y_W'(GRID_H - 1)) begin
          off_grid = 1'b1;
          pos_y_d  = '0;
        end else begin
          pos_y_d = pos_y_q + 1'b1;
        end
      end
      2'b10: begin
        if (pos_x_q == '0) begin
          off_grid = 1'b1;
          pos_x_d  = X_W'(GRID_W - 1);
        end else begin
          pos_x_d = pos_x_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pos_x_q   <= X_W'(START_X);
      pos_y_q   <= Y_W'(START_Y);
      dir_q     <= START_DIR;
      step_q    <= 1'b0;
      alive_q   <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      unique case (state_q)
        StIdle, StCrash: begin
          if (start_i) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            pos_x_q   <= X_W'(START_X);
            pos_y_q   <= Y_W'(START_Y);
            dir_q     <= START_DIR;
            alive_q   <= 1'b1;
            crashed_q <= 1'b0;
          end
        end
        StRun: begin
          // A crash outranks a move on the same tick; start is ignored while running.
          if (collision_i || (tick && off_grid && EdgeCrash)) begin
            state_q   <= StCrash;
            alive_q   <= 1'b0;
            crashed_q <= 1'b1;
          end else if (tick) begin
            cnt_q   <= '0;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_q   <= dir_filtered_i;
            step_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign direction_current_o = dir_q;
  assign pos_x_o             = pos_x_q;
  assign pos_y_o             = pos_y_q;
  assign step_valid_o        = step_q;
  assign alive_o             = alive_q;
  assign crashed_o           = crashed_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed steps then random stimulus against a grid-level model.
// Honours PLAYER_WRAP_EN the same way as the design.
module tb_player_motion_ctrl;

  localparam int GW = 160;
  localparam int GH = 120;
  localparam int TD = 4;
  localparam int SX = 20;
  localparam int SY = 60;
  localparam logic [1:0] SD = 2'b01;
  localparam int MIdle = 0, MRun = 1, MCrash = 2;

  logic       clk = 1'b0;
  logic       rst, start, collision;
  logic [1:0] dir_f;
  logic [1:0] dir_cur;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       step_valid, alive, crashed;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_mode, m_x, m_y, m_cycles;
  logic [1:0] m_dir;
  bit         m_sv;

  always #5 clk = ~clk;

  player_motion_ctrl #(
    .X_W(8), .Y_W(7), .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD),
    .START_X(SX), .START_Y(SY), .START_DIR(SD)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .dir_filtered_i      (dir_f),
    .collision_i         (collision),
    .direction_current_o (dir_cur),
    .pos_x_o             (pos_x),
    .pos_y_o             (pos_y),
    .step_valid_o        (step_valid),
    .alive_o             (alive),
    .crashed_o           (crashed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_x = SX; m_y = SY; m_dir = SD; m_cycles = 0; m_sv = 0;
  endtask

  // m_cycles counts cycles spent in the current round; every TD-th one is a move.
  task automatic model_edge();
    int nx, ny;
    m_sv = 0;
    if (m_mode != MRun) begin
      if (start) begin
        m_mode = MRun; m_x = SX; m_y = SY; m_dir = SD; m_cycles = 0;
      end
    end else if (collision) begin
      m_mode = MCrash;
    end else if ((m_cycles % TD) == TD - 1) begin
      nx = m_x + ((dir_f == 2'b01) ? 1 : (dir_f == 2'b10) ? -1 : 0);
      ny = m_y + ((dir_f == 2'b11) ? 1 : (dir_f == 2'b00) ? -1 : 0);
      m_cycles++;
`ifdef PLAYER_WRAP_EN
      m_x = (nx + GW) % GW; m_y = (ny + GH) % GH; m_dir = dir_f; m_sv = 1;
`else
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        m_mode = MCrash;
      end else begin
        m_x = nx; m_y = ny; m_dir = dir_f; m_sv = 1;
      end
`endif
    end else begin
      m_cycles++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"},       32'(pos_x),      32'(m_x));
    chk({tag, ".y"},       32'(pos_y),      32'(m_y));
    chk({tag, ".dir"},     32'(dir_cur),    32'(m_dir));
    chk({tag, ".step"},    32'(step_valid), 32'(m_sv));
    chk({tag, ".alive"},   32'(alive),      32'(m_mode == MRun));
    chk({tag, ".crashed"}, 32'(crashed),    32'(m_mode == MCrash));
  endtask

  task automatic cycle(input string tag, input logic st, input logic [1:0] d, input logic col);
    start = st; dir_f = d; collision = col;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [1:0] rd;
    rst = 1'b1; start = 1'b0; dir_f = 2'b01; collision = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) cycle("idle", 1'b0, 2'b01, 1'b0);
    chk("idle_x", 32'(pos_x), 32'd20);
    chk("idle_alive", 32'(alive), 32'd0);

    // First and second steps to the right
    cycle("start", 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) cycle("run_wait1", 1'b0, 2'b01, 1'b0);
    cycle("step1", 1'b0, 2'b01, 1'b0);
    chk("step1_x", 32'(pos_x), 32'd21);
    chk("step1_sv", 32'(step_valid), 32'd1);
    for (int i = 0; i < 3; i++) cycle("run_wait2", 1'b0, 2'b01, 1'b0);
    cycle("step2", 1'b0, 2'b01, 1'b0);
    chk("step2_x", 32'(pos_x), 32'd22);

    // Heading change mid-interval only commits on the tick
    cycle("mid1", 1'b0, 2'b01, 1'b0);
    cycle("mid2", 1'b0, 2'b00, 1'b0);
    chk("mid_dir_hold", 32'(dir_cur), 32'd1);
    cycle("mid3", 1'b0, 2'b00, 1'b0);
    cycle("turn", 1'b0, 2'b00, 1'b0);
    chk("turn_dir", 32'(dir_cur), 32'd0);
    chk("turn_y", 32'(pos_y), 32'd59);

    // Collision (with an ignored start) exactly on the tick
    for (int i = 0; i < TD && (m_cycles % TD) != TD - 1; i++) cycle("pre_tick", 1'b0, 2'b00, 1'b0);
    cycle("coll_tick", 1'b1, 2'b00, 1'b1);
    chk("coll_crashed", 32'(crashed), 32'd1);
    chk("coll_y", 32'(pos_y), 32'd59);
    chk("coll_sv", 32'(step_valid), 32'd0);
    for (int i = 0; i < 6; i++) cycle("crash_hold", 1'b0, 2'b11, 1'b0);
    cycle("restart", 1'b1, 2'b11, 1'b0);
    chk("restart_x", 32'(pos_x), 32'd20);
    chk("restart_dir", 32'(dir_cur), 32'd1);

    // Asynchronous reset with the counter at 2
    cycle("pre_rst1", 1'b0, 2'b11, 1'b0);
    cycle("pre_rst2", 1'b0, 2'b11, 1'b0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle("post_rst", 1'b0, 2'b00, 1'b0);

    // Run straight up into the top edge
    cycle("up_start", 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 260; i++) cycle("up_run", 1'b0, 2'b00, 1'b0);
`ifdef PLAYER_WRAP_EN
    chk("up_alive", 32'(alive), 32'd1);
    chk("up_y", 32'(pos_y), 32'd115);
`else
    chk("up_crashed", 32'(crashed), 32'd1);
    chk("up_y", 32'(pos_y), 32'd0);
`endif

    // Random play
    rd = 2'b10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) rd = 2'($urandom_range(3));
      cycle("rand", ($urandom_range(15) == 0), rd, ($urandom_range(149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
